// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, carry held in a flop. Optional ovf port under BIT_SERIAL_ADDER_OVF_EN.
// Latency: start accepted at edge E0 -> done pulse in the cycle after edge E_WIDTH; throughput one result per WIDTH+1 cycles.
// Backpressure: none; start is ignored while busy, results are held until the next operation completes.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_s;
    logic [WIDTH-1:0] sh_s_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last;
    logic             fa_s;
    logic             fa_c;

    // Full-adder cell on the current LSBs and the stored carry.
    assign fa_s     = sh_a[0] ^ sh_b[0] ^ carry;
    assign fa_c     = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
    assign sh_s_nxt = {fa_s, sh_s[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= last;
            if (accept) begin
                sh_a  <= a;
                sh_b  <= b;
                carry <= cin;
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (state == SHIFT) begin
                sh_a  <= sh_a >> 1;
                sh_b  <= sh_b >> 1;
                sh_s  <= sh_s_nxt;
                carry <= fa_c;
                cnt   <= cnt + CNT_W'(1);
                // Outputs only move on the final bit so they are never seen half-built.
                if (last) begin
                    sum  <= sh_s_nxt;
                    cout <= fa_c;
                    busy <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
                    ovf  <= carry ^ fa_c;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8): directed table, back-to-back, mid-op reset, random sweep.
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         cin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef BIT_SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, scramble inputs while busy, wait (bounded) for done.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic [W-1:0] es, input logic ec, input string name);
        int           lat;
        bit           seen;
        bit           held;
        logic [W-1:0] prev_s;
        logic         prev_c;
        prev_s = sum;
        prev_c = cout;
        held   = 1'b1;
        seen   = 1'b0;
        lat    = 0;
        a      = ta;
        b      = tb_;
        cin    = tc;
        start  = 1'b1;
        step();
        check({name, " busy_rise"}, 32'(busy), 32'd1);
        start = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            step();
            lat++;
            if (done) seen = 1'b1;
            else if (sum !== prev_s || cout !== prev_c || busy !== 1'b1) held = 1'b0;
        end
        if (!seen) begin
            check({name, " timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, " latency"}, 32'(lat), 32'(W));
            check({name, " hold"}, 32'(held), 32'd1);
            check({name, " sum"}, 32'(sum), 32'(es));
            check({name, " cout"}, 32'(cout), 32'(ec));
            check({name, " busy_at_done"}, 32'(busy), 32'd0);
`ifdef BIT_SERIAL_ADDER_OVF_EN
            begin
                logic [W-1:0] low;
                logic         c_msb;
                low   = {1'b0, ta[W-2:0]} + {1'b0, tb_[W-2:0]} + W'(tc);
                c_msb = low[W-1];
                check({name, " ovf"}, 32'(ovf), 32'(c_msb ^ ec));
            end
`endif
        end
    endtask

    initial begin
        vec_t         vt[8];
        logic [W-1:0] ba[3];
        logic [W-1:0] bb[3];
        logic         bc[3];
        logic [W-1:0] bs[3];
        logic         bco[3];
        int           stray;

        vt[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, s: 8'h96, c: 1'b0};
        vt[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, c: 1'b1};
        vt[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, c: 1'b1};
        vt[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, c: 1'b0};
        vt[4] = '{a: 8'h00, b: 8'h00, cin: 1'b1, s: 8'h01, c: 1'b0};
        vt[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, c: 1'b1};
        vt[6] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, s: 8'h00, c: 1'b1};
        vt[7] = '{a: 8'h12, b: 8'h34, cin: 1'b0, s: 8'h46, c: 1'b0};

        // Reset state
        step();
        step();
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst sum", 32'(sum), 32'd0);
        check("rst cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].s, vt[i].c, $sformatf("vec%0d", i));
            step();
            check($sformatf("vec%0d done_drop", i), 32'(done), 32'd0);
        end

        // Reset in the 4th SHIFT cycle of 0x12+0x34; sum currently holds 0x46
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst sum", 32'(sum), 32'd0);
        check("midrst cout", 32'(cout), 32'd0);
        step(); step();
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done || busy) stray++;
        end
        check("midrst no_done", 32'(stray), 32'd0);
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "post_rst");
        step();

        // start held high; operands are junk except on accepting edges (every 9 cycles)
        ba = '{8'h5A, 8'hFF, 8'hC3};
        bb = '{8'h3C, 8'h01, 8'h3D};
        bc = '{1'b0, 1'b0, 1'b1};
        bs = '{8'h96, 8'h00, 8'h01};
        bco = '{1'b0, 1'b1, 1'b1};
        a = ba[0]; b = bb[0]; cin = bc[0]; start = 1'b1;
        for (int j = 0; j < 27; j++) begin
            step();
            check($sformatf("b2b done j%0d", j), 32'(done), 32'((j % 9) == 8));
            if ((j % 9) == 8) begin
                check($sformatf("b2b sum j%0d", j), 32'(sum), 32'(bs[j / 9]));
                check($sformatf("b2b cout j%0d", j), 32'(cout), 32'(bco[j / 9]));
            end else begin
                check($sformatf("b2b busy j%0d", j), 32'(busy), 32'd1);
            end
            if (((j + 1) % 9) == 0) begin
                if ((j + 1) / 9 < 3) begin
                    a = ba[(j + 1) / 9]; b = bb[(j + 1) / 9]; cin = bc[(j + 1) / 9];
                end else begin
                    start = 1'b0;
                end
            end else begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
        end
        step();
        check("b2b idle", 32'(busy), 32'd0);

`ifdef BIT_SERIAL_ADDER_OVF_EN
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "ovf_pos");
        check("ovf_pos flag", 32'(ovf), 32'd1);
        step();
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ovf_wrap");
        check("ovf_wrap flag", 32'(ovf), 32'd0);
        step();
`endif

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            logic [W:0]   ref_sum;
            ra      = W'($urandom);
            rb      = W'($urandom);
            rc      = 1'($urandom);
            ref_sum = {1'b0, ra} + {1'b0, rb} + (W + 1)'(rc);
            repeat ($urandom_range(0, 3)) step();
            run_op(ra, rb, rc, ref_sum[W-1:0], ref_sum[W], $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
